sw_debounce_edge: RTL

- Upstream conditioning stage for push-button and switch inputs that feed the LED/ring-counter logic.
- Synchronizes a raw asynchronous switch into the system clock domain and filters contact bounce with a counter-based state machine.
- Emits a clean debounced level, single-cycle rise/fall/long-press strobes, and a wrapping press counter.
- Downstream blocks use rise_o as their "load/restart" event instead of doing their own edge detection on the raw switch.

---
 rtl/sw_debounce_edge.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sw_debounce_edge.sv
// sw_debounce_edge: brings a raw switch into the clk_i domain, debounces it with a
// counter FSM and emits a clean level, rise/fall/long-press strobes and a press count.
module sw_debounce_edge #(
   parameter int unsigned DEBOUNCE_CYCLES   = 250_000,
   parameter int unsigned LONG_PRESS_CYCLES = 25_000_000,
   parameter int unsigned COUNT_W           = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               sw_i,
   output logic               level_o,
   output logic               rise_o,
   output logic               fall_o,
   output logic               long_o,
   output logic [COUNT_W-1:0] press_count_o
);

   localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);

   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
   localparam logic [COUNT_W-1:0] PRESS_ONE = COUNT_W'(1);

   typedef enum logic [1:0] {
      ST_LOW       = 2'd0,
      ST_RISE_WAIT = 2'd1,
      ST_HIGH      = 2'd2,
      ST_FALL_WAIT = 2'd3
   } state_e;

   logic               sync1_q, sync1_d;
   logic               s_q, s_d;
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic               long_done_q, long_done_d;
   logic               level_q, level_d;
   logic               rise_q, rise_d;
   logic               fall_q, fall_d;
   logic               long_q, long_d;
   logic [COUNT_W-1:0] press_q, press_d;

   // State register: synchronizer, FSM, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q     <= 1'b0;
         s_q         <= 1'b0;
         state_q     <= ST_LOW;
         cnt_q       <= {CNT_W{1'b0}};
         hold_q      <= {HOLD_W{1'b0}};
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         long_q      <= 1'b0;
         press_q     <= {COUNT_W{1'b0}};
      end else begin
         sync1_q     <= sync1_d;
         s_q         <= s_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         long_q      <= long_d;
         press_q     <= press_d;
      end
   end

   // Next-state logic: debounce FSM, long-press timer and strobe generation.
   always_comb begin
      sync1_d     = sw_i;
      s_d         = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      long_d      = 1'b0;
      press_d     = press_q;

      // The hold timer only runs while the debounced level is high; it saturates
      // at its last value and long_done blocks repeat strobes until the next rise.
      if ((state_q == ST_HIGH) || (state_q == ST_FALL_WAIT)) begin
         if (hold_q == HOLD_LAST) begin
            if (!long_done_q) begin
               long_d      = 1'b1;
               long_done_d = 1'b1;
            end else begin
               long_d      = 1'b0;
            end
         end else begin
            hold_d = hold_q + HOLD_ONE;
         end
      end else begin
         hold_d = hold_q;
      end

      case (state_q)
         ST_LOW: begin
            if (s_q) begin
               state_d = ST_RISE_WAIT;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = ST_LOW;
            end
         end
         ST_RISE_WAIT: begin
            if (!s_q) begin
               state_d = ST_LOW;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_HIGH;
               level_d     = 1'b1;
               rise_d      = 1'b1;
               press_d     = press_q + PRESS_ONE;
               hold_d      = {HOLD_W{1'b0}};
               long_done_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!s_q) begin
               state_d = ST_FALL_WAIT;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = ST_HIGH;
            end
         end
         ST_FALL_WAIT: begin
            if (s_q) begin
               state_d = ST_HIGH;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = {CNT_W{1'b0}};
            level_d = 1'b0;
         end
      endcase
   end

   assign level_o       = level_q;
   assign rise_o        = rise_q;
   assign fall_o        = fall_q;
   assign long_o        = long_q;
   assign press_count_o = press_q;

endmodule
